// File: rtl/dadda_mul_pipe_if.sv
// Operand/product handshake bundle for dadda_mul_pipe.
// The master side drives operands and consumes products. The slave side is the multiplier.
interface dadda_mul_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 signed_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   op;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, op
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, op
   );
endinterface

// File: rtl/dadda_mul_pipe.sv
// Pipelined WIDTH x WIDTH Dadda-tree multiplier with valid/ready handshake.
// Partial products use Baugh-Wooley form, so one tree serves both signed and unsigned operands.
// The Dadda reduction levels are spread over the first STAGES-1 register stages.
// The last stage holds the carry-propagate adder.
// The product register is the final stage. Its latency is STAGES edges, counting the accept edge.
module dadda_mul_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 3
) (
   input logic             clk,
   input logic             rst_n,
   dadda_mul_pipe_if.slave bus
);
   localparam int unsigned NCOL = 2 * WIDTH;
   localparam int unsigned MAXH = WIDTH;

   // Bit matrix: one column per product weight, rows packed from index 0 upward.
   // Entries above a column's height are always zero.
   typedef logic [NCOL-1:0][MAXH-1:0] mat_t;
   typedef logic [NCOL-1:0][31:0]     hts_t;

   // Number of Dadda levels needed to bring a WIDTH-high matrix down to two rows.
   function automatic int unsigned num_levels();
      int unsigned d = 2;
      int unsigned n = 0;
      for (int unsigned k = 0; k < 16; k++) begin
         if (d < MAXH) begin
            n++;
            d = (d * 3) / 2;
         end
      end
      return n;
   endfunction

   localparam int unsigned NLEV = num_levels();

   // Target height of level lv. Level 0 is the tallest target, and the last level targets 2.
   function automatic int unsigned level_target(input int unsigned lv);
      int unsigned d = 2;
      for (int unsigned k = 0; k < 16; k++) begin
         if (k + lv + 1 < NLEV) d = (d * 3) / 2;
      end
      return d;
   endfunction

   // Column heights of the Baugh-Wooley matrix, including the two signed-mode correction bits.
   function automatic hts_t init_heights();
      hts_t h = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         for (int unsigned j = 0; j < WIDTH; j++)
            h[i+j] = h[i+j] + 1;
      h[WIDTH]  = h[WIDTH] + 1;
      h[NCOL-1] = h[NCOL-1] + 1;
      return h;
   endfunction

   // Partial products. In signed mode, terms that contain exactly one sign bit are inverted.
   // Ones are also added at weights WIDTH and 2*WIDTH-1. In unsigned mode these reduce to plain ANDs.
   function automatic mat_t pp_gen(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic sm);
      mat_t m   = '0;
      hts_t cnt = '0;
      int unsigned c;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         for (int unsigned j = 0; j < WIDTH; j++) begin
            c = i + j;
            m[c][cnt[c]] = (x[i] & y[j]) ^ (sm & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            cnt[c] = cnt[c] + 1;
         end
      end
      m[WIDTH][cnt[WIDTH]]   = sm;
      m[NCOL-1][cnt[NCOL-1]] = sm;
      return m;
   endfunction

   // One Dadda level. Columns are scanned LSB first. The column's bits and the carries arriving
   // from the column below form a pool. Full adders (or one final half adder) are applied until
   // the column height is at most d. Carries out of the top column are dropped (mod 2^(2*WIDTH)).
   function automatic void dadda_level(input mat_t m_in, input hts_t h_in, input int unsigned d,
                                       output mat_t m_out, output hts_t h_out);
      logic [2*MAXH-1:0] pool;
      logic [MAXH-1:0]   c_in;
      logic [MAXH-1:0]   c_out;
      int unsigned       n_cin, n_cout, n_pool, src, n_out, h;
      logic              x, y, z;
      m_out = '0;
      h_out = '0;
      c_in  = '0;
      n_cin = 0;
      for (int unsigned c = 0; c < NCOL; c++) begin
         pool   = '0;
         n_pool = 0;
         for (int unsigned r = 0; r < MAXH; r++) begin
            if (r < h_in[c]) begin
               pool[n_pool] = m_in[c][r];
               n_pool++;
            end
         end
         for (int unsigned r = 0; r < MAXH; r++) begin
            if (r < n_cin) begin
               pool[n_pool] = c_in[r];
               n_pool++;
            end
         end
         h      = n_pool;
         src    = 0;
         n_out  = 0;
         c_out  = '0;
         n_cout = 0;
         for (int unsigned r = 0; r < 2 * MAXH; r++) begin
            if (h > d + 1) begin
               x = pool[src];
               y = pool[src+1];
               z = pool[src+2];
               src += 3;
               m_out[c][n_out] = x ^ y ^ z;
               c_out[n_cout]   = (x & y) | (z & (x ^ y));
               n_out++;
               n_cout++;
               h -= 2;
            end else if (h == d + 1) begin
               x = pool[src];
               y = pool[src+1];
               src += 2;
               m_out[c][n_out] = x ^ y;
               c_out[n_cout]   = x & y;
               n_out++;
               n_cout++;
               h -= 1;
            end
         end
         for (int unsigned r = 0; r < 2 * MAXH; r++) begin
            if (r >= src && r < n_pool) begin
               m_out[c][n_out] = pool[r];
               n_out++;
            end
         end
         h_out[c] = n_out;
         c_in     = c_out;
         n_cin    = n_cout;
      end
   endfunction

   // Column heights before level n. These depend only on parameters, so they fold to constants.
   function automatic hts_t heights_at(input int unsigned n);
      mat_t m = '0;
      hts_t h = init_heights();
      for (int unsigned lv = 0; lv < NLEV; lv++)
         if (lv < n) dadda_level(m, h, level_target(lv), m, h);
      return h;
   endfunction

   // Apply levels [lo, hi) to a matrix that has already been through levels [0, lo).
   function automatic mat_t reduce_range(input mat_t m_in, input int unsigned lo,
                                         input int unsigned hi);
      mat_t m = m_in;
      hts_t h = heights_at(lo);
      for (int unsigned lv = 0; lv < NLEV; lv++)
         if (lv >= lo && lv < hi) dadda_level(m, h, level_target(lv), m, h);
      return m;
   endfunction

   // Final carry-propagate add of the two remaining rows.
   function automatic logic [NCOL-1:0] cpa(input mat_t m);
      logic [NCOL-1:0] r0;
      logic [NCOL-1:0] r1;
      for (int unsigned c = 0; c < NCOL; c++) begin
         r0[c] = m[c][0];
         r1[c] = m[c][1];
      end
      return r0 + r1;
   endfunction

   // Split the levels evenly over the stages that come before the CPA stage.
   // With a single stage, everything runs in front of the output register.
   function automatic int unsigned seg_lo(input int unsigned s);
      if (STAGES == 1) return 0;
      return (s * NLEV) / (STAGES - 1);
   endfunction

   function automatic int unsigned seg_hi(input int unsigned s);
      int unsigned v;
      if (STAGES == 1) return NLEV;
      v = ((s + 1) * NLEV) / (STAGES - 1);
      return (v > NLEV) ? NLEV : v;
   endfunction

   logic                advance;
   logic [STAGES-1:0]   stg_v;
   logic                last_in_v;
   logic [NCOL-1:0]     prod;
   logic [NCOL-1:0]     op_q;

   assign advance       = bus.out_ready | ~bus.out_valid;
   assign bus.in_ready  = advance;
   assign bus.out_valid = stg_v[STAGES-1];
   assign bus.op        = op_q;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      mat_t m_in;
      mat_t m_out;

      if (s == 0) begin : g_first
         // Generate partial products from the operands currently offered.
         always_comb m_in = pp_gen(bus.a, bus.b, bus.signed_mode);
      end else begin : g_next
         // Take the matrix registered by the previous stage.
         always_comb m_in = g_stage[s-1].g_reg.m_q;
      end

      // Reduction levels assigned to this stage.
      always_comb m_out = reduce_range(m_in, seg_lo(s), seg_hi(s));

      if (s < STAGES - 1) begin : g_reg
         mat_t m_q;
         // Partially reduced matrix moves one stage per advance and holds on stall.
         always_ff @(posedge clk) begin
            if (advance) m_q <= m_out;
         end
      end else begin : g_last
         // Two-row result of the reduction feeds the carry-propagate adder.
         always_comb prod = cpa(m_out);
      end
   end

   if (STAGES == 1) begin : g_lv_single
      assign last_in_v = bus.in_valid;
   end else begin : g_lv_multi
      assign last_in_v = stg_v[STAGES-2];
   end

   // Valid bits shift one stage per advance. Reset discards everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stg_v <= '0;
      else if (advance) stg_v <= (stg_v << 1) | STAGES'(bus.in_valid);
   end

   // The product register loads only when a real transaction enters the output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) op_q <= '0;
      else if (advance && last_in_v) op_q <= prod;
   end
endmodule

// File: tb/tb_dadda_mul_pipe.sv
// Directed bench for dadda_mul_pipe at three parameter points: (8,3), (16,4) and (4,1).
`timescale 1ns/1ps
module tb_dadda_mul_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   dadda_mul_pipe_if #(.WIDTH(8))  i8  ();
   dadda_mul_pipe_if #(.WIDTH(16)) i16 ();
   dadda_mul_pipe_if #(.WIDTH(4))  i4  ();

   dadda_mul_pipe #(.WIDTH(8),  .STAGES(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
   dadda_mul_pipe #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));
   dadda_mul_pipe #(.WIDTH(4),  .STAGES(1)) dut4  (.clk(clk), .rst_n(rst_n), .bus(i4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv8(input logic v, input logic [7:0] x, input logic [7:0] y, input logic sm);
      i8.in_valid = v; i8.a = x; i8.b = y; i8.signed_mode = sm;
   endtask

   task automatic drv16(input logic v, input logic [15:0] x, input logic [15:0] y, input logic sm);
      i16.in_valid = v; i16.a = x; i16.b = y; i16.signed_mode = sm;
   endtask

   task automatic drv4(input logic v, input logic [3:0] x, input logic [3:0] y, input logic sm);
      i4.in_valid = v; i4.a = x; i4.b = y; i4.signed_mode = sm;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0]        expq[$];
      int unsigned        sent, recv, cyc;
      logic [7:0]         ra, rb;
      logic               rsm;
      logic signed [15:0] sa, sb;
      logic [15:0]        e16;

      rst_n = 1'b0;
      drv8(0, 8'h00, 8'h00, 0);  i8.out_ready  = 1'b0;
      drv16(0, 16'h0, 16'h0, 0); i16.out_ready = 1'b0;
      drv4(0, 4'h0, 4'h0, 0);    i4.out_ready  = 1'b0;
      #3;
      chk("rst8_out_valid", i8.out_valid, 0);
      chk("rst8_op", i8.op, 0);
      chk("rst8_in_ready", i8.in_ready, 1);
      chk("rst16_out_valid", i16.out_valid, 0);
      chk("rst4_op", i4.op, 0);
      step();
      step();
      rst_n = 1'b1;
      i8.out_ready = 1'b1; i16.out_ready = 1'b1; i4.out_ready = 1'b1;

      // Unsigned latency: 0x2B * 0x09
      drv8(1, 8'h2B, 8'h09, 0);
      step();
      drv8(0, 8'h00, 8'h00, 0);
      chk("lat_e0_valid", i8.out_valid, 0);
      step();
      chk("lat_e1_valid", i8.out_valid, 0);
      step();
      chk("lat_e2_valid", i8.out_valid, 1);
      chk("lat_e2_op", i8.op, 16'h0183);
      step();
      chk("lat_e3_valid", i8.out_valid, 0);

      // 0xFF * 0xFF unsigned
      drv8(1, 8'hFF, 8'hFF, 0);
      step();
      drv8(0, 8'h00, 8'h00, 0);
      step();
      step();
      chk("ffff_valid", i8.out_valid, 1);
      chk("ffff_op", i8.op, 16'hFE01);
      step();

      // Mode switch back to back, then most-negative squared
      drv8(1, 8'hEB, 8'h09, 0);
      step();
      drv8(1, 8'hEB, 8'h09, 1);
      step();
      drv8(1, 8'h80, 8'h80, 1);
      step();
      drv8(0, 8'h00, 8'h00, 0);
      chk("mode_u_valid", i8.out_valid, 1);
      chk("mode_u_op", i8.op, 16'h0843);
      step();
      chk("mode_s_op", i8.op, 16'hFF43);
      step();
      chk("mode_neg_sq_op", i8.op, 16'h4000);
      step();
      chk("mode_drained", i8.out_valid, 0);

      // Backpressure
      i8.out_ready = 1'b0;
      drv8(1, 8'h2B, 8'h09, 0);
      step();
      drv8(1, 8'h2B, 8'h49, 0);
      step();
      drv8(1, 8'h2B, 8'h0B, 0);
      step();
      drv8(0, 8'h00, 8'h00, 0);
      chk("bp_valid", i8.out_valid, 1);
      chk("bp_in_ready", i8.in_ready, 0);
      chk("bp_op", i8.op, 16'h0183);
      step();
      step();
      chk("bp_hold_valid", i8.out_valid, 1);
      chk("bp_hold_in_ready", i8.in_ready, 0);
      chk("bp_hold_op", i8.op, 16'h0183);
      i8.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", i8.in_ready, 1);
      chk("bp_drain0", i8.op, 16'h0183);
      step();
      chk("bp_drain1_valid", i8.out_valid, 1);
      chk("bp_drain1", i8.op, 16'h0C43);
      step();
      chk("bp_drain2_valid", i8.out_valid, 1);
      chk("bp_drain2", i8.op, 16'h01D9);
      step();
      chk("bp_empty", i8.out_valid, 0);

      // Random stream with random in_valid/out_ready
      sent = 0; recv = 0; cyc = 0;
      while ((sent < 20 || recv < sent) && cyc < 400) begin
         if (sent < 20 && $urandom_range(0, 3) != 0) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rsm = 1'($urandom_range(0, 1));
            drv8(1, ra, rb, rsm);
         end else begin
            drv8(0, 8'h00, 8'h00, 0);
         end
         i8.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (i8.in_valid && i8.in_ready) begin
            sa  = {{8{ra[7]}}, ra};
            sb  = {{8{rb[7]}}, rb};
            e16 = rsm ? 16'(sa * sb) : 16'({8'h00, ra} * {8'h00, rb});
            expq.push_back(e16);
            sent++;
         end
         if (i8.out_valid && i8.out_ready) begin
            if (expq.size() > 0) chk("stream_op", i8.op, expq.pop_front());
            else chk("stream_extra_out", i8.out_valid, 0);
            recv++;
         end
         step();
         cyc++;
      end
      drv8(0, 8'h00, 8'h00, 0);
      i8.out_ready = 1'b1;
      chk("stream_sent", sent, 20);
      chk("stream_count", recv, sent);
      step();
      step();
      step();

      // Reset mid-stream
      drv8(1, 8'h11, 8'h11, 0);
      step();
      drv8(1, 8'h22, 8'h22, 0);
      step();
      drv8(1, 8'h33, 8'h33, 0);
      step();
      drv8(0, 8'h00, 8'h00, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", i8.out_valid, 0);
      chk("midrst_op", i8.op, 0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("postrst_quiet", i8.out_valid, 0);
      end
      drv8(1, 8'h2B, 8'h0B, 0);
      step();
      drv8(0, 8'h00, 8'h00, 0);
      step();
      chk("postrst_lat1", i8.out_valid, 0);
      step();
      chk("postrst_valid", i8.out_valid, 1);
      chk("postrst_op", i8.op, 16'h01D9);
      step();

      // WIDTH=16, STAGES=4
      drv16(1, 16'hFFFF, 16'hFFFF, 0);
      step();
      drv16(0, 16'h0, 16'h0, 0);
      chk("w16_e0", i16.out_valid, 0);
      step();
      chk("w16_e1", i16.out_valid, 0);
      step();
      chk("w16_e2", i16.out_valid, 0);
      step();
      chk("w16_valid", i16.out_valid, 1);
      chk("w16_op", i16.op, 32'hFFFE0001);
      drv16(1, 16'h8000, 16'h8000, 1);
      step();
      drv16(1, 16'hFFFF, 16'hFFFF, 1);
      step();
      drv16(0, 16'h0, 16'h0, 0);
      step();
      step();
      chk("w16_neg_sq", i16.op, 32'h40000000);
      step();
      chk("w16_m1_sq", i16.op, 32'h00000001);
      step();
      chk("w16_empty", i16.out_valid, 0);

      // WIDTH=4, STAGES=1
      drv4(1, 4'h8, 4'h8, 1);
      step();
      chk("w4_valid", i4.out_valid, 1);
      chk("w4_neg_sq", i4.op, 8'h40);
      drv4(1, 4'hF, 4'hF, 0);
      step();
      chk("w4_uns", i4.op, 8'hE1);
      drv4(1, 4'h7, 4'h8, 1);
      step();
      chk("w4_mixed_sign", i4.op, 8'hC8);
      drv4(0, 4'h0, 4'h0, 0);
      step();
      chk("w4_empty", i4.out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
